dcache_ctrl: RTL
================

Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache with one word per line.
- Sits between the CPU MEM stage (data address, write data, MemRead/MemWrite) and a slower word-wide backing data memory that uses a req/ack handshake.
- Hits complete in the same cycle, so the MEM stage is unchanged on a hit.
- Misses raise cpu_stall_o, which the pipeline uses to freeze every stage register until the miss is resolved.

Parameters:
- INDEX_W, 5: index bits; number of lines = 2^INDEX_W.
- TAG_W, 25: tag bits; must equal 30-INDEX_W.
- CNT_W, 16: width of the hit and miss statistic counters.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  synchronous reset, active high.
- cpu_addr_i  in  32  byte address; bits[1:0] ignored; index = [INDEX_W+1:2], tag = [31:INDEX_W+2].
- cpu_wdata_i  in  32  store data.
- cpu_read_i  in  1  load request (MemRead).
- cpu_write_i  in  1  store request (MemWrite).
- cpu_rdata_o  out  32  load data; combinational on a read hit, otherwise 0.
- cpu_stall_o  out  1  high while the current access is not yet complete.
- mem_req_o  out  1  backing-memory request, held until ack.
- mem_we_o  out  1  1 = write-back, 0 = line fill.
- mem_addr_o  out  32  word-aligned backing address, bits[1:0] = 0.
- mem_wdata_o  out  32  victim data during write-back.
- mem_rdata_i  in  32  fill data, valid when mem_ack_i = 1.
- mem_ack_i  in  1  one-cycle completion strobe.
- hit_cnt_o  out  CNT_W  accesses that hit on first lookup; saturating.
- miss_cnt_o  out  CNT_W  misses detected; saturating.

Behaviour:
- Storage per line: valid, dirty, tag, 32-bit data.
- Reset: all valid and dirty bits cleared, state = IDLE, hit_cnt_o = 0, miss_cnt_o = 0, mem_req_o = 0, mem_we_o = 0, mem_addr_o = 0, mem_wdata_o = 0.
- Reset during WRITEBACK or FILL abandons the transaction; mem_req_o is 0 from the reset edge on.
- Request definition: req = cpu_read_i | cpu_write_i. If both are high, the access is a write.
- Hit definition: hit = valid[idx] & (tag[idx] == cpu tag).
- cpu_stall_o = (state != IDLE) | (req & ~hit), combinational.
- cpu_rdata_o = data[idx] when state = IDLE & cpu_read_i & hit; otherwise 0.
- States: IDLE, WRITEBACK, FILL.
- IDLE, read hit: zero latency; hit_cnt_o increments.
- IDLE, write hit: data[idx] <= cpu_wdata_i and dirty <= 1 at the edge; no stall; hit_cnt_o increments.
- IDLE, miss: on the next edge, latch the miss address, the victim tag and the victim data into registers, and increment miss_cnt_o.
  - Victim valid & dirty: go to WRITEBACK.
  - Otherwise: go to FILL.
- WRITEBACK:
  - Outputs: mem_req_o = 1, mem_we_o = 1, mem_addr_o = {victim tag, idx, 2'b00}, mem_wdata_o = victim data.
  - All four are stable until ack.
  - On mem_ack_i: go to FILL.
- FILL:
  - Outputs: mem_req_o = 1, mem_we_o = 0, mem_addr_o = {latched miss addr[31:2], 2'b00}.
  - On mem_ack_i, the line becomes valid with the new tag.
  - Miss was a read: data <= mem_rdata_i, dirty <= 0.
  - Miss was a write: data <= cpu_wdata_i, dirty <= 1.
  - Then go to IDLE.
- After FILL the access hits in IDLE in the next cycle. That cycle deasserts stall, returns the data and does not increment hit_cnt_o.
- Miss penalty: clean miss = 2 + L cycles of stall, where L is the ack delay in cycles after request. Dirty miss adds 1 + L.
- The CPU holds cpu_addr_i, cpu_wdata_i and the request signals stable while cpu_stall_o = 1. Changes while stalled are unsupported.
- mem_ack_i is ignored when mem_req_o = 0.
- mem_req_o drops in the cycle after ack and rises again in the same cycle as the state change into FILL.
- Counters saturate at all-ones and never wrap.
- No request (req = 0) in IDLE: no state change, no counter change.

Test Plan:
- Cold read: after reset, read 0x40, memory returns 0x11112222 with a 2-cycle ack delay.
  - Required: one FILL request at 0x40 with mem_we_o = 0.
  - Required: stall for 4 cycles, then cpu_rdata_o = 0x11112222; miss_cnt_o = 1, hit_cnt_o = 0.
- Read hit: repeat the read of 0x40.
  - Required: cpu_stall_o = 0 and data returned in the same cycle.
  - Required: hit_cnt_o = 1 and no mem_req_o activity.
- Write hit then conflict eviction: write 0xDEADBEEF to 0x40 with no stall, then read 0xC0 (same index 16, tag 1).
  - Required: WRITEBACK at 0x40 with data 0xDEADBEEF, then FILL at 0xC0.
  - Required: miss_cnt_o = 2.
- Write miss allocate: write 0x5 to 0x80 on an empty line.
  - Required: FILL at 0x80; the line ends dirty with data 0x5.
  - Required: a later conflicting read at 0x100 triggers a WRITEBACK of 0x5 to 0x80.
- Reset mid-FILL: assert rst_i while mem_req_o = 1.
  - Required: at the next edge mem_req_o = 0, state is IDLE and both counters are 0.
  - Required: re-reading the same address misses again.
- Counter saturation: with CNT_W = 4, perform 20 hits.
  - Required: hit_cnt_o stays at 0xF.

Source files
------------

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate data cache, one word per line.
// Hits finish in the lookup cycle; misses stall the pipeline via cpu_stall_o.
module dcache_ctrl #(
  parameter int INDEX_W = 5,
  parameter int TAG_W   = 25,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      cpu_addr_i,
  input  logic [31:0]      cpu_wdata_i,
  input  logic             cpu_read_i,
  input  logic             cpu_write_i,
  output logic [31:0]      cpu_rdata_o,
  output logic             cpu_stall_o,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_wdata_o,
  input  logic [31:0]      mem_rdata_i,
  input  logic             mem_ack_i,
  output logic [CNT_W-1:0] hit_cnt_o,
  output logic [CNT_W-1:0] miss_cnt_o
);

  localparam int LINES = 1 << INDEX_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WB,
    S_FILL
  } state_t;

  state_t state_q, state_d;

  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] dirty_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  logic [31:2]      miss_addr_q;
  logic             miss_we_q;
  logic [TAG_W-1:0] vtag_q;
  logic [31:0]      vdata_q;
  logic             fill_done_q;
  logic [CNT_W-1:0] hit_cnt_q;
  logic [CNT_W-1:0] miss_cnt_q;

  logic [INDEX_W-1:0] idx;
  logic [INDEX_W-1:0] fidx;
  logic [TAG_W-1:0]   ctag;
  logic               req;
  logic               hit;
  logic               idle;
  logic               fill_ack;
  logic               unused_addr;

  assign idx         = cpu_addr_i[INDEX_W+1:2];
  assign ctag        = cpu_addr_i[31:INDEX_W+2];
  assign fidx        = miss_addr_q[INDEX_W+1:2];
  assign req         = cpu_read_i | cpu_write_i;
  assign hit         = valid_q[idx] & (tag_q[idx] == ctag);
  assign idle        = (state_q == S_IDLE);
  assign fill_ack    = (state_q == S_FILL) & mem_ack_i;
  assign unused_addr = ^cpu_addr_i[1:0];

  assign cpu_stall_o = ~idle | (req & ~hit);
  assign cpu_rdata_o = (idle & cpu_read_i & hit) ? data_q[idx] : 32'h0;
  assign hit_cnt_o   = hit_cnt_q;
  assign miss_cnt_o  = miss_cnt_q;

  // Next state and backing-memory request outputs
  always_comb begin
    state_d     = state_q;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = 32'h0;
    mem_wdata_o = 32'h0;
    unique case (state_q)
      S_IDLE: begin
        if (req & ~hit) begin
          state_d = (valid_q[idx] & dirty_q[idx]) ? S_WB : S_FILL;
        end
      end
      S_WB: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {vtag_q, fidx, 2'b00};
        mem_wdata_o = vdata_q;
        if (mem_ack_i) state_d = S_FILL;
      end
      S_FILL: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {miss_addr_q, 2'b00};
        if (mem_ack_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state: FSM, line status bits, miss latches and statistics
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      valid_q     <= '0;
      dirty_q     <= '0;
      miss_addr_q <= '0;
      miss_we_q   <= 1'b0;
      vtag_q      <= '0;
      vdata_q     <= '0;
      fill_done_q <= 1'b0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      fill_done_q <= fill_ack;
      if (idle & req & hit) begin
        if (cpu_write_i) dirty_q[idx] <= 1'b1;
        if (~fill_done_q && hit_cnt_q != '1) begin
          hit_cnt_q <= hit_cnt_q + CNT_W'(1);
        end
      end
      if (idle & req & ~hit) begin
        miss_addr_q <= cpu_addr_i[31:2];
        miss_we_q   <= cpu_write_i;
        vtag_q      <= tag_q[idx];
        vdata_q     <= data_q[idx];
        if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
      end
      if (fill_ack) begin
        valid_q[fidx] <= 1'b1;
        dirty_q[fidx] <= miss_we_q;
      end
    end
  end

  // Tag and data arrays: store hits and line fills
  always_ff @(posedge clk_i) begin
    if (idle & cpu_write_i & hit) data_q[idx] <= cpu_wdata_i;
    if (fill_ack) begin
      tag_q[fidx]  <= miss_addr_q[31:INDEX_W+2];
      data_q[fidx] <= miss_we_q ? cpu_wdata_i : mem_rdata_i;
    end
  end

endmodule
